seq_mult_shift_add: RTL

- Parametrised sequential shift-and-add multiplier; successor to the 4x4 combinational array multiplier.
- Generalised to WIDTH-bit operands, with a runtime signed/unsigned mode and valid/ready handshakes on both sides.
- Trades area for latency: one partial product per cycle, reusing a single WIDTH+1-bit adder.
- Sits behind the tt_um top-level wrapper or any streaming datapath that supplies operand pairs.

---
 rtl/seq_mult_shift_add.sv | 125 ++++++++++++
 1 files changed

// File: rtl/seq_mult_shift_add.sv
// rtl/seq_mult_shift_add.sv - sequential shift-and-add multiplier, signed/unsigned, valid/ready on both sides
// One partial product per cycle through a single WIDTH+1-bit adder; sign applied after the magnitude product.
module seq_mult_shift_add #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mag;
  logic                 w_last;

  // Magnitudes stay WIDTH bits wide, so the most negative value maps to 2^(WIDTH-1).
  always_comb begin
    w_a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
    w_b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;
    w_sum   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_mcand}) : {1'b0, r_hi};
    w_mag   = {w_sum, r_lo[WIDTH-1:1]};
    w_last  = (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = S_BUSY;
        end
      end
      S_BUSY: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand <= w_a_mag;
            r_lo    <= w_b_mag;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        S_BUSY: begin
          // Shift {carry, accumulator, multiplier} right by one after the conditional add.
          r_hi  <= w_sum[WIDTH:1];
          r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_product <= r_neg ? -w_mag : w_mag;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign product = r_product;

endmodule
